// File: rtl/skid_reg.sv
// Two-entry valid/ready skid buffer: registers data/valid and ready so that
// neither path is combinational, while sustaining one word per cycle.
module skid_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  s_fire;
    logic                  m_fire;

    // Handshake outputs come straight from the state flops, so there is no
    // input-to-output combinational path.
    assign m_valid = (state != EMPTY);
    assign s_ready = (state != FULL);
    assign count   = state;
    assign m_data  = main_q;

    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (s_fire) begin
                        main_q <= s_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_fire && m_fire) begin
                        main_q <= s_data;
                    end else if (s_fire) begin
                        // Word in flight while downstream stalls lands in skid.
                        skid_q <= s_data;
                        state  <= FULL;
                    end else if (m_fire) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (m_fire) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_skid_reg.sv
// Scoreboard bench for skid_reg: directed reset/fill/stream cases plus
// random valid/ready traffic checked against an in-order queue.
module tb_skid_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_q[$];
    logic          mon_en = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    skid_reg #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: at the falling edge the inputs for the next rising edge are
    // settled, so fires seen here are the ones that edge will execute.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb_q.delete();
                prev_hold = 1'b0;
            end else begin
                check("count_vs_model", {30'd0, count}, sb_q.size());
                if (prev_hold)
                    check("m_data_stable", m_data, prev_data);
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0)
                        check("output_underflow", 1, 0);
                    else
                        check("sb_data", m_data, sb_q.pop_front());
                end
                if (s_valid && s_ready)
                    sb_q.push_back(s_data);
                prev_hold = m_valid & ~m_ready;
                prev_data = m_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int budget;
        logic fired;

        // Reset with junk on the input.
        rst = 1'b1; s_valid = 1'b1; s_data = 16'hAAAA; m_ready = 1'b0;
        repeat (3) tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_count", count, 0);
        check("rst_m_data", m_data, 0);
        rst = 1'b0; s_valid = 1'b0;
        mon_en = 1'b1;
        tick();
        check("rst_no_capture", m_valid, 0);

        // Single word held under backpressure.
        s_valid = 1'b1; s_data = 16'h1234;
        tick();
        s_valid = 1'b0;
        check("single_m_valid", m_valid, 1);
        check("single_m_data", m_data, 16'h1234);
        check("single_count", count, 1);
        tick();
        check("single_hold_valid", m_valid, 1);
        check("single_hold_data", m_data, 16'h1234);
        m_ready = 1'b1;
        tick();
        check("single_drained", m_valid, 0);

        // Back-to-back streaming.
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            check("stream_s_ready", s_ready, 1);
            tick();
            check("stream_m_valid", m_valid, 1);
            check("stream_m_data", m_data, i);
            check("stream_count", count, 1);
        end
        s_valid = 1'b0;
        tick();
        check("stream_done", m_valid, 0);

        // Skid fill.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h0001;
        tick();
        s_data = 16'h0002;
        tick();
        check("fill_count", count, 2);
        check("fill_s_ready", s_ready, 0);
        s_data = 16'h0003;
        tick();
        check("fill_hold_count", count, 2);
        check("fill_hold_data", m_data, 16'h0001);
        m_ready = 1'b1;
        tick();
        check("fill_rel1_data", m_data, 16'h0002);
        check("fill_rel1_count", count, 1);
        tick();
        s_valid = 1'b0;
        check("fill_rel2_data", m_data, 16'h0003);
        tick();
        check("fill_empty", m_valid, 0);

        // Random traffic.
        sent = 0; budget = 0;
        s_valid = 1'b0; m_ready = 1'b0;
        while (sent < 1000 && budget < 20000) begin
            if (!s_valid) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = DW'($urandom);
            end
            m_ready = 1'($urandom_range(0, 1));
            fired = s_valid & s_ready;
            tick();
            budget++;
            if (count > 2'd2) check("rand_count_max", count, 2);
            if (fired) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        check("rand_all_sent", sent, 1000);
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (4) tick();
        check("rand_drained", sb_q.size(), 0);

        // Reset while full.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h0BAD;
        tick();
        s_data = 16'h0BEE;
        tick();
        check("rstfull_count", count, 2);
        s_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstfull_m_valid", m_valid, 0);
        check("rstfull_count0", count, 0);
        check("rstfull_s_ready", s_ready, 1);
        check("rstfull_m_data", m_data, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstfull_no_emit", m_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_reg.md
# skid_reg

Two-entry valid/ready register slice (skid buffer) that accepts a data word from an upstream producer and presents it downstream one cycle later. It is the receiving-side companion to the plain reset-able data flop: that flop only launches data, while this block absorbs it under backpressure without dropping or duplicating words. It is used to break timing paths on both data/valid and ready between pipeline stages, and sustains full throughput of one word per cycle.

## Interface
- DATA_WIDTH, 16, width of the data word carried through the slice

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- s_valid  input  1  upstream word valid
- s_ready  output  1  slice can accept a word this cycle
- s_data  input  DATA_WIDTH  upstream word
- m_valid  output  1  downstream word valid
- m_ready  input  1  downstream accepts the word this cycle
- m_data  output  DATA_WIDTH  downstream word
- count  output  2  words held (0, 1 or 2)

## Operation
- Storage: main register (drives m_data) and skid register.
- s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- States: EMPTY (0 words), BUSY (main full), FULL (main and skid full).
- Outputs decoded from state flops only: m_valid = (state != EMPTY); s_ready = (state != FULL); count = 0/1/2 for EMPTY/BUSY/FULL. No combinational path from any input to any output.
- EMPTY: s_fire -> main <= s_data, go BUSY. Otherwise hold.
- BUSY: s_fire & m_fire -> main <= s_data, stay BUSY. s_fire & !m_fire -> skid <= s_data, go FULL. !s_fire & m_fire -> go EMPTY. Neither -> hold.
- FULL: s_ready = 0, so no s_fire. m_fire -> main <= skid, go BUSY. Otherwise hold.
- Ordering strictly FIFO; no word is dropped, duplicated or reordered.
- s_data is sampled only on s_fire; m_data is stable while m_valid & !m_ready.
- s_valid while s_ready = 0 is a no-op; the upstream holds its word until s_ready returns.
- Data registers are not cleared when leaving a state; m_data value while m_valid = 0 is don't-care but must be deterministic (last loaded value, or zero after reset).

## Timing
- Reset: on a rising edge with rst = 1, state <= EMPTY, main <= 0, skid <= 0. After that edge: m_valid = 0, s_ready = 1, count = 0, m_data = 0. All inputs ignored on reset edges.
- Reset mid-operation: any held words are discarded in the same edge; no word is emitted after a reset edge.
- Latency: word accepted at edge N appears with m_valid = 1 after edge N (available for consumption in cycle N+1).
- Throughput: with m_ready held high, one word per cycle indefinitely, state stays BUSY, s_ready stays 1.
- Backpressure: m_ready low for one cycle while streaming -> FULL after that edge; s_ready drops for at least one cycle; resumes after next m_fire.
- s_ready deasserts only in the cycle after the second word is captured; the skid register absorbs the word in flight.

## Test plan
- Reset: hold rst = 1 three cycles with s_valid = 1, s_data = 0xAAAA -> m_valid = 0, s_ready = 1, count = 0, m_data = 0; no word captured.
- Single word: after reset, one cycle s_valid = 1, s_data = 0x1234, m_ready = 0 -> next cycle m_valid = 1, m_data = 0x1234, count = 1; stays until m_ready = 1, then m_valid = 0.
- Streaming: 100 words 0x0000..0x0063 back to back, m_ready = 1 -> output matches input in order, one per cycle, s_ready never low, count never 2.
- Skid fill: send 0x0001, 0x0002, 0x0003 on consecutive cycles with m_ready = 0 -> count reaches 2, s_ready = 0, 0x0003 held upstream; release m_ready -> output 0x0001, 0x0002, 0x0003 in order, no loss.
- Random backpressure: 1000 random words, random s_valid and m_ready (50%) -> scoreboard exact match, m_data stable whenever m_valid & !m_ready, count never exceeds 2.
- Reset while FULL: fill to count = 2, assert rst one cycle -> next cycle m_valid = 0, count = 0, s_ready = 1; neither held word ever appears on m_data with m_valid = 1.
